// File: rtl/pll_reset_sequencer_pkg.sv
// Shared clocking package: sequencer state encoding, default count
// parameters and a small sizing helper for the shared cycle counter.
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_PLL_RST_CYCLES = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 4096;
  localparam int unsigned DEF_LOCK_STABLE    = 256;
  localparam int unsigned DEF_MAX_RETRIES    = 7;

  // Largest of the three count parameters; sets the shared counter width.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// Two-flop synchronizer for a single asynchronous level (e.g. PLL lock).
// Both stages clear on reset so the synchronized level starts low.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values simply shift the input down the two-stage chain.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: holds the PLL in reset, waits for synchronized lock,
// requires a stable lock window, then releases the system reset. Retries
// on lock timeout, gives up after MAX_RETRIES, and re-runs on lock loss.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned LOCK_STABLE    = DEF_LOCK_STABLE,
  parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_count,
  output logic [3:0] loss_count
);

  localparam int unsigned CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic             lock_s;
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic [3:0]       loss_q, loss_d;
  logic             pll_resetb_q, pll_resetb_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;

  sync2 u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Next state, counter and status counters; outputs are decoded from the
  // next state so they register on the same edge the state is entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    loss_d  = loss_q;

    unique case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_q + 3'd1;
          state_d = (retry_d == 3'(MAX_RETRIES)) ? ST_FAIL : ST_PLL_RST;
          cnt_d   = '0;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = ST_PLL_RST;
          retry_d = '0;
          if (loss_q != 4'hF) loss_d = loss_q + 4'd1;
        end
      end
      ST_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
      end
    endcase

    if (restart) begin
      state_d = ST_PLL_RST;
      cnt_d   = '0;
      retry_d = '0;
    end

    pll_resetb_d = !((state_d == ST_PLL_RST) || (state_d == ST_FAIL));
    sys_rst_d    = (state_d != ST_RUN);
    ready_d      = (state_d == ST_RUN);
    fail_d       = (state_d == ST_FAIL);
  end

  // State, counters and registered outputs, all forced on async reset.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_PLL_RST;
      cnt_q        <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      pll_resetb_q <= 1'b0;
      sys_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pll_resetb_q <= pll_resetb_d;
      sys_rst_q    <= sys_rst_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
    end
  end

  assign pll_resetb  = pll_resetb_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign fail        = fail_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;

endmodule
